// File: rtl/keccak_pkg_mine.sv
// Shared Keccak constants: rate sizes, lane width, mode encodings and
// words-per-block counts for the SHAKE squeeze path.
package keccak_pkg_mine;

  localparam int w             = 64;
  localparam int RATE_SHAKE128 = 1344;
  localparam int RATE_SHAKE256 = 1088;

  localparam logic [10:0] RATE_SHAKE128_VEC = 11'd1344;
  localparam logic [10:0] RATE_SHAKE256_VEC = 11'd1088;

  localparam logic [1:0] SHAKE128_MODE_VEC = 2'b10;
  localparam logic [1:0] SHAKE256_MODE_VEC = 2'b11;

  localparam logic [4:0] WPB_SHAKE128 = 5'd21;
  localparam logic [4:0] WPB_SHAKE256 = 5'd17;

endpackage

// File: rtl/shake_squeeze_serializer_pkg.sv
// Serializer-local types and helpers: FSM encoding, mode decode,
// per-mode word count and per-word valid-bit count.
package shake_squeeze_serializer_pkg;
  import keccak_pkg_mine::*;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // True for the two squeeze modes this stage can serialize.
  function automatic logic mode_supported(input logic [1:0] mode);
    return (mode == SHAKE128_MODE_VEC) || (mode == SHAKE256_MODE_VEC);
  endfunction

  // Lanes per rate block; unsupported modes never reach SEND.
  function automatic logic [4:0] wpb_for(input logic [1:0] mode);
    return (mode == SHAKE256_MODE_VEC) ? WPB_SHAKE256 : WPB_SHAKE128;
  endfunction

  // Valid bits in the next word: min(remaining, 64).
  function automatic logic [6:0] word_bits(input logic [31:0] rem);
    return (rem >= 32'd64) ? 7'd64 : rem[6:0];
  endfunction

endpackage

// File: rtl/shake_squeeze_serializer_if.sv
// Block-in / word-out stream bundle of the squeeze serializer.
// master = upstream producer + downstream consumer side, slave = serializer.
interface shake_squeeze_serializer_if #(
  parameter int W        = 64,
  parameter int RATE_MAX = 1344
);
  logic                block_valid;
  logic                block_ready;
  logic [RATE_MAX-1:0] rate_in;
  logic [1:0]          operation_mode_in;
  logic [31:0]         output_size_in;
  logic [W-1:0]        dout;
  logic                dout_valid;
  logic                dout_ready;
  logic [6:0]          dout_bits;
  logic                dout_last;
  logic                mode_error;

  modport master (
    output block_valid, rate_in, operation_mode_in, output_size_in, dout_ready,
    input  block_ready, dout, dout_valid, dout_bits, dout_last, mode_error
  );

  modport slave (
    input  block_valid, rate_in, operation_mode_in, output_size_in, dout_ready,
    output block_ready, dout, dout_valid, dout_bits, dout_last, mode_error
  );
endinterface

// File: rtl/regn_mine.sv
// Plain N-bit register with asynchronous active-low clear.
module regn_mine #(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  // Capture d every cycle; clear immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/shake_squeeze_serializer_lane_selector.sv
// Indexed lane mux over the rate block plus the tail mask that keeps only
// the top `bits` bits of the selected lane (bits = 0 yields all zeros).
module lane_selector #(
  parameter int W        = 64,
  parameter int RATE_MAX = 1344
) (
  input  logic [RATE_MAX-1:0] block,
  input  logic [4:0]          idx,
  input  logic [6:0]          bits,
  output logic [W-1:0]        word
);

  localparam int NLANES = RATE_MAX / W;

  logic [W-1:0] lane_s;
  logic [W-1:0] mask_s;

  // Pick lane idx; lane 0 sits at the top of the block.
  always_comb begin
    lane_s = '0;
    for (int i = 0; i < NLANES; i++) begin
      if (idx == 5'(i)) begin
        lane_s = block[RATE_MAX-1-i*W -: W];
      end else begin
        lane_s = lane_s;
      end
    end
  end

  // Keep the top `bits` bits; a shift of W or more clears the shifted ones.
  always_comb begin
    mask_s = ~({W{1'b1}} >> bits);
    word   = lane_s & mask_s;
  end

endmodule

// File: rtl/shake_squeeze_serializer.sv
// SHAKE squeeze output stage: takes one rate block per squeeze and emits it
// as 64-bit lane words on a valid/ready stream, truncated to the requested
// output length, with the final word flagged.
module shake_squeeze_serializer
  import keccak_pkg_mine::*;
  import shake_squeeze_serializer_pkg::*;
#(
  parameter int W        = w,
  parameter int RATE_MAX = RATE_SHAKE128
) (
  input logic                      clk,
  input logic                      rst,
  shake_squeeze_serializer_if.slave bus
);

  state_e              state_q, state_d;
  logic [4:0]          word_idx_q, word_idx_d;
  logic                dout_valid_q, dout_valid_d;
  logic [6:0]          dout_bits_q, dout_bits_d;
  logic                dout_last_q, dout_last_d;
  logic                mode_error_q, mode_error_d;
  logic [RATE_MAX-1:0] block_q, block_d;
  logic [1:0]          mode_q, mode_d;
  logic [31:0]         rem_q, rem_d;

  logic [4:0]          wpb_s;
  logic                hs_s;
  logic                end_s;
  logic                block_ready_s;
  logic                load_s;
  logic                send_s;
  logic [W-1:0]        word_s;

  regn_mine #(.N(RATE_MAX)) u_block_reg (.clk(clk), .rst_n(rst), .d(block_d), .q(block_q));
  regn_mine #(.N(2))        u_mode_reg  (.clk(clk), .rst_n(rst), .d(mode_d),  .q(mode_q));
  regn_mine #(.N(32))       u_rem_reg   (.clk(clk), .rst_n(rst), .d(rem_d),   .q(rem_q));

  lane_selector #(.W(W), .RATE_MAX(RATE_MAX)) u_lane_selector (
    .block (block_q),
    .idx   (word_idx_q),
    .bits  (dout_bits_q),
    .word  (word_s)
  );

  // Handshake and end-of-block detection; block_ready reopens in the final
  // handshake cycle so a waiting block can follow without a bubble.
  always_comb begin
    wpb_s         = wpb_for(mode_q);
    hs_s          = dout_valid_q && bus.dout_ready;
    end_s         = hs_s && (dout_last_q || (word_idx_q == (wpb_s - 5'd1)));
    block_ready_s = (state_q == ST_IDLE) || end_s;
    load_s        = block_ready_s && bus.block_valid;
  end

  // Next-state: load a block, advance a word, or close the block.
  // The output flops are derived from the next state so they are registered.
  always_comb begin
    state_d      = state_q;
    word_idx_d   = word_idx_q;
    mode_error_d = mode_error_q;
    block_d      = block_q;
    mode_d       = mode_q;
    rem_d        = rem_q;
    if (load_s) begin
      block_d    = bus.rate_in;
      mode_d     = bus.operation_mode_in;
      rem_d      = bus.output_size_in;
      word_idx_d = 5'd0;
      if (!mode_supported(bus.operation_mode_in)) begin
        mode_error_d = 1'b1;
        state_d      = ST_IDLE;
      end else if (bus.output_size_in == 32'd0) begin
        state_d = ST_IDLE;
      end else begin
        state_d = ST_SEND;
      end
    end else if (end_s) begin
      rem_d      = rem_q - {25'd0, dout_bits_q};
      word_idx_d = 5'd0;
      state_d    = ST_IDLE;
    end else if (hs_s) begin
      rem_d      = rem_q - {25'd0, dout_bits_q};
      word_idx_d = word_idx_q + 5'd1;
    end else begin
      state_d = state_q;
    end
    send_s       = (state_d == ST_SEND);
    dout_valid_d = send_s;
    dout_bits_d  = send_s ? word_bits(rem_d) : 7'd0;
    dout_last_d  = send_s && (rem_d <= 32'd64);
  end

  // FSM state, word index and registered stream outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      word_idx_q   <= 5'd0;
      dout_valid_q <= 1'b0;
      dout_bits_q  <= 7'd0;
      dout_last_q  <= 1'b0;
      mode_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_idx_q   <= word_idx_d;
      dout_valid_q <= dout_valid_d;
      dout_bits_q  <= dout_bits_d;
      dout_last_q  <= dout_last_d;
      mode_error_q <= mode_error_d;
    end
  end

  assign bus.block_ready = block_ready_s;
  assign bus.dout        = word_s;
  assign bus.dout_valid  = dout_valid_q;
  assign bus.dout_bits   = dout_bits_q;
  assign bus.dout_last   = dout_last_q;
  assign bus.mode_error  = mode_error_q;

endmodule

// File: tb/tb_shake_squeeze_serializer.sv
// Self-checking bench for the SHAKE squeeze serializer. A queue-based model
// expands every accepted block into its expected word list; the DUT stream
// is compared against it every cycle under random backpressure.
module tb_shake_squeeze_serializer;

  localparam int RM = 1344;

  typedef struct {
    logic [63:0] data;
    logic [6:0]  bits;
    logic        last;
    logic        endblk;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  shake_squeeze_serializer_if #(.W(64), .RATE_MAX(RM)) bus ();

  shake_squeeze_serializer #(.W(64), .RATE_MAX(RM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  exp_t          exp_q[$];
  logic [RM-1:0] pend_rate[$];
  logic [1:0]    pend_mode[$];
  logic [31:0]   pend_size[$];
  logic          model_err = 1'b0;
  int            ready_pct = 100;
  int            words_sent = 0;

  logic          stalled_prev = 1'b0;
  logic [63:0]   prev_data;
  logic [6:0]    prev_bits;
  logic          prev_last;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Lane k of a block: shift it to the top and take the upper 64 bits.
  function automatic logic [63:0] lane_of(input logic [RM-1:0] r, input int k);
    logic [RM-1:0] t;
    t = r << (k * 64);
    return t[RM-1:RM-64];
  endfunction

  // Keep only the n most significant bits of v.
  function automatic logic [63:0] keep_top(input logic [63:0] v, input int n);
    logic [63:0] o;
    o = '0;
    for (int b = 0; b < n; b++) o[63-b] = v[63-b];
    return o;
  endfunction

  // Expand one accepted block into its expected output words.
  task automatic model_block(input logic [RM-1:0] r, input logic [1:0] mode, input logic [31:0] size);
    longint rem;
    int     wpb;
    int     nb;
    exp_t   e;
    if (mode != 2'b10 && mode != 2'b11) begin
      model_err = 1'b1;
      return;
    end
    wpb = (mode == 2'b10) ? 21 : 17;
    rem = longint'(size);
    for (int k = 0; k < wpb && rem > 0; k++) begin
      nb       = (rem > 64) ? 64 : int'(rem);
      e.data   = keep_top(lane_of(r, k), nb);
      e.bits   = 7'(nb);
      e.last   = (rem <= 64);
      e.endblk = (rem <= 64) || (k == wpb - 1);
      exp_q.push_back(e);
      rem -= nb;
    end
  endtask

  task automatic push_block(input logic [1:0] mode, input logic [31:0] size);
    logic [RM-1:0] r;
    for (int i = 0; i < RM / 32; i++) r[i*32 +: 32] = $urandom;
    pend_rate.push_back(r);
    pend_mode.push_back(mode);
    pend_size.push_back(size);
  endtask

  // One clock: check outputs, drive inputs, check block_ready, update model.
  task automatic cycle();
    logic hs;
    logic exp_br;
    @(negedge clk);
    chk("dout_valid", 64'(bus.dout_valid), 64'(exp_q.size() != 0));
    chk("mode_error", 64'(bus.mode_error), 64'(model_err));
    if (exp_q.size() != 0) begin
      chk("dout", bus.dout, exp_q[0].data);
      chk("dout_bits", 64'(bus.dout_bits), 64'(exp_q[0].bits));
      chk("dout_last", 64'(bus.dout_last), 64'(exp_q[0].last));
    end else begin
      chk("idle_dout", bus.dout, 64'd0);
      chk("idle_bits", 64'(bus.dout_bits), 64'd0);
      chk("idle_last", 64'(bus.dout_last), 64'd0);
    end
    if (stalled_prev) begin
      chk("stall_dout", bus.dout, prev_data);
      chk("stall_bits", 64'(bus.dout_bits), 64'(prev_bits));
      chk("stall_last", 64'(bus.dout_last), 64'(prev_last));
    end
    bus.dout_ready = ($urandom_range(99) < ready_pct);
    if (pend_rate.size() != 0) begin
      bus.block_valid       = 1'b1;
      bus.rate_in           = pend_rate[0];
      bus.operation_mode_in = pend_mode[0];
      bus.output_size_in    = pend_size[0];
    end else begin
      bus.block_valid = 1'b0;
    end
    #1;
    hs     = (exp_q.size() != 0) && bus.dout_ready;
    exp_br = (exp_q.size() == 0) || (hs && exp_q[0].endblk);
    chk("block_ready", 64'(bus.block_ready), 64'(exp_br));
    stalled_prev = (exp_q.size() != 0) && !bus.dout_ready;
    prev_data    = bus.dout;
    prev_bits    = bus.dout_bits;
    prev_last    = bus.dout_last;
    if (hs) begin
      void'(exp_q.pop_front());
      words_sent++;
    end
    if (bus.block_valid && exp_br) begin
      model_block(pend_rate[0], pend_mode[0], pend_size[0]);
      void'(pend_rate.pop_front());
      void'(pend_mode.pop_front());
      void'(pend_size.pop_front());
    end
  endtask

  task automatic run_until_idle(input int limit);
    int c;
    c = 0;
    while ((pend_rate.size() != 0 || exp_q.size() != 0) && c < limit) begin
      cycle();
      c++;
    end
    chk("drain_timeout", 64'(c < limit), 64'd1);
    cycle();
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_block_ready"}, 64'(bus.block_ready), 64'd1);
    chk({tag, "_dout_valid"},  64'(bus.dout_valid),  64'd0);
    chk({tag, "_dout"},        bus.dout,             64'd0);
    chk({tag, "_dout_bits"},   64'(bus.dout_bits),   64'd0);
    chk({tag, "_dout_last"},   64'(bus.dout_last),   64'd0);
    chk({tag, "_mode_error"},  64'(bus.mode_error),  64'd0);
  endtask

  initial begin
    int c;
    bus.block_valid       = 1'b0;
    bus.rate_in           = '0;
    bus.operation_mode_in = 2'b00;
    bus.output_size_in    = 32'd0;
    bus.dout_ready        = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk_reset_values("rst");
    rst = 1'b1;

    // Full SHAKE128 block, no truncation.
    ready_pct = 100;
    push_block(2'b10, 32'd2688);
    run_until_idle(200);

    // SHAKE256 truncated to 4 words.
    push_block(2'b11, 32'd256);
    run_until_idle(200);

    // SHAKE128 with a partial tail word (64 + 36 bits).
    push_block(2'b10, 32'd100);
    run_until_idle(200);

    // Random backpressure with back-to-back blocks.
    ready_pct = 60;
    for (int i = 0; i < 6; i++) begin
      push_block(($urandom_range(1) == 0) ? 2'b10 : 2'b11, 32'($urandom_range(3000, 1)));
    end
    push_block(2'b11, 32'd5000);
    push_block(2'b10, 32'd64);
    run_until_idle(3000);

    // Reset at word 7 of a SHAKE128 block.
    ready_pct  = 100;
    words_sent = 0;
    push_block(2'b10, 32'd2688);
    c = 0;
    while (words_sent < 7 && c < 100) begin
      cycle();
      c++;
    end
    chk("reset_reach_timeout", 64'(c < 100), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_values("midrst");
    exp_q.delete();
    pend_rate.delete();
    pend_mode.delete();
    pend_size.delete();
    bus.block_valid = 1'b0;
    stalled_prev    = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    push_block(2'b10, 32'd640);
    run_until_idle(200);

    // Unsupported mode, then a valid block, then a zero-length block.
    ready_pct = 70;
    push_block(2'b00, 32'd500);
    run_until_idle(50);
    push_block(2'b11, 32'd1000);
    push_block(2'b10, 32'd0);
    push_block(2'b01, 32'd64);
    push_block(2'b10, 32'd130);
    run_until_idle(500);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/shake_squeeze_serializer.md
# shake_squeeze_serializer

Output stage of the SHAKE pipeline. It consumes the rate blocks the permute stage produces, one per squeeze, together with the operation mode and the remaining output size. It serializes each block into 64-bit lane words on a valid/ready stream toward the consumer (sampler, hash sink), truncating to the requested output length. It discards any lanes beyond the requested length and flags the final word.

## Interface
Parameters:
- `W`, default 64: lane and output word width in bits. Must equal `w`.
- `RATE_MAX`, default `RATE_SHAKE128`: width of the block input in bits (1344).

Ports (clock and reset first):
- `clk`  in  1  — single clock; all state is on its rising edge.
- `rst`  in  1  — asynchronous, active-low reset.
- `block_valid`  in  1  — upstream has a squeezed block.
- `block_ready`  out  1  — stage can take a block this cycle.
- `rate_in`  in  RATE_MAX  — rate block. Lane 0 is at `[RATE_MAX-1 -: W]`, already byte-ordered for output.
- `operation_mode_in`  in  2  — `SHAKE128_MODE_VEC` or `SHAKE256_MODE_VEC`.
- `output_size_in`  in  32  — output bits still owed, counting this block.
- `dout`  out  W  — output word.
- `dout_valid`  out  1  — `dout` holds a valid word.
- `dout_ready`  in  1  — consumer accepts the word.
- `dout_bits`  out  7  — number of valid bits in `dout`, 1..64. Zero when `dout_valid` is low.
- `dout_last`  out  1  — this word completes the requested output.
- `mode_error`  out  1  — sticky. Set when a block arrives with an unsupported mode.

## Operation
- FSM states are IDLE and SEND.
- IDLE:
  - `block_ready` = 1.
  - On `block_valid`, capture `rate_in`, mode and `output_size_in` into the block register, mode register and remaining register. Clear `word_idx`.
  - Go to SEND if the mode is valid and `output_size_in` > 0.
  - If the mode is invalid, set `mode_error`, drop the block and stay in IDLE.
  - If `output_size_in` = 0, drop the block silently and stay in IDLE.
- Words per block (`wpb`): 21 for SHAKE128, 17 for SHAKE256, i.e. `RATE_*_VEC / W`.
- SEND:
  - `dout` = lane `word_idx` of the block register.
  - `dout_bits` = min(remaining, 64).
  - Only bits `dout[63 -: dout_bits]` are driven from the lane; lower bits are forced to 0.
  - `dout_last` = (remaining ≤ 64).
- On a `dout_valid && dout_ready` handshake:
  - remaining decrements by `dout_bits`; `word_idx` increments.
  - The block ends when `dout_last` is set or `word_idx` = `wpb`-1. Any unsent lanes are discarded.
- End of block:
  - `block_ready` is asserted combinationally in the same cycle as the final handshake.
  - If `block_valid` is also high, the next block is loaded and SEND continues with no bubble.
  - Otherwise the FSM returns to IDLE.
- Width rules:
  - remaining is 32-bit unsigned and never underflows.
  - `word_idx` is 5 bits and never exceeds `wpb`-1.

## Timing
- Reset values:
  - `block_ready` = 1; `dout_valid` = 0; `dout` = 0; `dout_bits` = 0; `dout_last` = 0; `mode_error` = 0; state = IDLE.
  - All registers are cleared asynchronously as soon as `rst` goes low.
- Latency: block accepted in cycle N gives the first `dout_valid` in cycle N+1.
- Throughput: one word per cycle while `dout_ready` is held high. Block-to-block transition has no idle cycle.
- Backpressure: while `dout_valid` is high and `dout_ready` is low, `dout`, `dout_bits` and `dout_last` hold stable.
- `block_ready` is low in SEND except in the final-handshake cycle.
- Reset mid-block: all state is lost, the partial block is not resumed, and upstream must re-present.
- `mode_error` clears only on reset.

## Structure
- Shared package (`keccak_pkg_mine`) holds: `RATE_SHAKE128`, `RATE_SHAKE256`, their `_VEC` block sizes, `w`, and the mode encodings. Add `WPB_SHAKE128` = 21 and `WPB_SHAKE256` = 17 there.
- Reuse `regn_mine` for the block, mode and remaining registers.
- One natural sub-module: `lane_selector`, a combinational indexed lane mux from the block register plus the tail mask from `dout_bits`.

## Test plan
- SHAKE128 with `output_size_in` = 2688 → 21 words equal lanes 0..20, all `dout_bits` = 64, `dout_last` = 0 throughout. `block_ready` is high in the 21st handshake cycle.
- SHAKE256 with `output_size_in` = 256 → 4 words with `dout_last` on the 4th. Lanes 4..16 are dropped, and `block_ready` rises on the 4th handshake.
- SHAKE128 with `output_size_in` = 100 → 2 words with `dout_bits` 64 then 36. On the second word, `dout[27:0]` = 0 and `dout_last` = 1.
- Random `dout_ready` backpressure plus back-to-back blocks → outputs stable while stalled. The second block's lane 0 appears the cycle after the first block's final handshake.
- `rst` pulled low at word 7 of a SHAKE128 block → all outputs at reset values immediately. The next block restarts from lane 0.
- Mode 2'b00 presented → `mode_error` = 1, no `dout_valid`, `block_ready` stays 1. A following valid block streams normally and `mode_error` stays set.
